// File: rtl/eth_rx_pkt_pkg.sv
// Shared types and helpers for the store-and-forward Ethernet RX packet buffer.
package eth_rx_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DROP
    } wr_state_t;

    localparam int CNT_W = 32;

    // Pointers carry one extra wrap bit above the address bits.
    function automatic logic ptr_full(
        input logic [31:0] wr,
        input logic [31:0] rd,
        input int          addr_w
    );
        logic [31:0] mask;
        mask = (32'd1 << (addr_w + 1)) - 32'd1;
        return ((wr ^ rd) & mask) == (32'd1 << addr_w);
    endfunction

endpackage

// File: rtl/eth_rx_buf_ram.sv
// Simple dual-port frame RAM with a registered, enable-gated read port.
module eth_rx_buf_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read data only changes on a read, so it doubles as an output slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/eth_rx_pkt_buffer.sv
// Store-and-forward RX buffer: frames are released only after an error-free tlast.
// Drop counters exist only when ETH_RX_PKT_BUFFER_STATS_EN is defined.
module eth_rx_pkt_buffer
    import eth_rx_pkt_pkg::*;
#(
    parameter int  DATA_W     = 512,
    parameter int  DEPTH      = 512,
    parameter int  MAX_FRAMES = 32,
    localparam int KEEP_W     = DATA_W / 8,
    localparam int FP_W       = $clog2(MAX_FRAMES) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_tvalid,
    input  logic [DATA_W-1:0] rx_tdata,
    input  logic [KEEP_W-1:0] rx_tkeep,
    input  logic              rx_tuser,
    input  logic              rx_tlast,
    output logic              so_tvalid,
    input  logic              so_tready,
    output logic [DATA_W-1:0] so_tdata,
    output logic [KEEP_W-1:0] so_tkeep,
    output logic              so_tlast,
    output logic [FP_W-1:0]   frames_pending,
    output logic [CNT_W-1:0]  drop_err_cnt,
    output logic [CNT_W-1:0]  drop_ovf_cnt
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int WORD_W = DATA_W + KEEP_W + 1;
    localparam logic [ADDR_W:0] PTR_ONE = 1;
    localparam logic [FP_W-1:0] FP_ONE  = 1;

    wr_state_t         state, state_nxt;
    logic [ADDR_W:0]   wr_ptr, commit_ptr, rd_ptr;
    logic              full, fq_full, beat;
    logic              ovf, err, rollback, wr_en, commit;
    logic              rd_en, rv, sv, dec;
    logic [WORD_W-1:0] ram_q, skid, out_word;

    assign full    = ptr_full(32'(wr_ptr), 32'(rd_ptr), ADDR_W);
    assign fq_full = frames_pending == FP_W'(MAX_FRAMES);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, WRITE: begin
                if (beat)
                    state_nxt = rx_tlast ? IDLE : (ovf ? DROP : WRITE);
            end
            DROP: begin
                if (rx_tvalid && rx_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        beat     = rx_tvalid && (state != DROP);
        ovf      = beat && ((state == IDLE && fq_full) || full);
        err      = beat && !ovf && rx_tlast && rx_tuser;
        rollback = ovf || err;
        wr_en    = beat && !ovf && !(rx_tlast && rx_tuser);
        commit   = wr_en && rx_tlast;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
        end else begin
            if (rollback)   wr_ptr <= commit_ptr;
            else if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (commit)     commit_ptr <= wr_ptr + PTR_ONE;
        end
    end

    eth_rx_buf_ram #(
        .WIDTH  (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (wr_en),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata ({rx_tlast, rx_tkeep, rx_tdata}),
        .re    (rd_en),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (ram_q)
    );

    // Two output slots: RAM read register (rv) and an older skid beat (sv).
    assign rd_en = (rd_ptr != commit_ptr) && (!sv || so_tready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            rv     <= 1'b0;
            sv     <= 1'b0;
            skid   <= '0;
        end else if (rd_en) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            rv     <= 1'b1;
            sv     <= rv && (sv || !so_tready);
            if (rv && (sv || !so_tready)) skid <= ram_q;
        end else if (rv && so_tready) begin
            rv <= sv;
            sv <= 1'b0;
        end
    end

    assign out_word  = sv ? skid : ram_q;
    assign so_tvalid = rv;
    assign so_tdata  = out_word[DATA_W-1:0];
    assign so_tkeep  = out_word[DATA_W +: KEEP_W];
    assign so_tlast  = out_word[WORD_W-1];
    assign dec       = rv && so_tready && so_tlast;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)               frames_pending <= '0;
        else if (commit && !dec) frames_pending <= frames_pending + FP_ONE;
        else if (!commit && dec) frames_pending <= frames_pending - FP_ONE;
    end

`ifdef ETH_RX_PKT_BUFFER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    logic [CNT_W-1:0] err_cnt, ovf_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt <= '0;
            ovf_cnt <= '0;
        end else begin
            if (err && err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
            if (ovf && ovf_cnt != '1) ovf_cnt <= ovf_cnt + CNT_ONE;
        end
    end

    assign drop_err_cnt = err_cnt;
    assign drop_ovf_cnt = ovf_cnt;
`else
    assign drop_err_cnt = '0;
    assign drop_ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_rx_pkt_buffer.sv
// Directed bench for eth_rx_pkt_buffer with a frame-level reference model.
module tb_eth_rx_pkt_buffer;

    localparam int DW    = 32;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 16;
    localparam int MAXF  = 4;
    localparam int WW    = DW + KW + 1;
`ifdef ETH_RX_PKT_BUFFER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          rx_tvalid = 1'b0;
    logic [DW-1:0] rx_tdata = '0;
    logic [KW-1:0] rx_tkeep = '0;
    logic          rx_tuser = 1'b0;
    logic          rx_tlast = 1'b0;
    logic          so_tready = 1'b0;
    logic          so_tvalid;
    logic [DW-1:0] so_tdata;
    logic [KW-1:0] so_tkeep;
    logic          so_tlast;
    logic [2:0]    frames_pending;
    logic [31:0]   drop_err_cnt;
    logic [31:0]   drop_ovf_cnt;

    eth_rx_pkt_buffer #(
        .DATA_W     (DW),
        .DEPTH      (DEPTH),
        .MAX_FRAMES (MAXF)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .rx_tvalid      (rx_tvalid),
        .rx_tdata       (rx_tdata),
        .rx_tkeep       (rx_tkeep),
        .rx_tuser       (rx_tuser),
        .rx_tlast       (rx_tlast),
        .so_tvalid      (so_tvalid),
        .so_tready      (so_tready),
        .so_tdata       (so_tdata),
        .so_tkeep       (so_tkeep),
        .so_tlast       (so_tlast),
        .frames_pending (frames_pending),
        .drop_err_cnt   (drop_err_cnt),
        .drop_ovf_cnt   (drop_ovf_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frames become visible as whole units on a good tlast.
    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] cur[$];
    int            pend = 0;
    int            err_m = 0;
    int            ovf_m = 0;
    int            buffered = 0;
    bit            in_frame = 0;
    bit            dropping = 0;
    int            out_beats = 0;
    logic [KW-1:0] last_keep = '0;
    bit            prev_stall = 0;
    logic [WW-1:0] prev_word = '0;

    always @(negedge clk) begin
        logic [WW-1:0] w;
        logic [WW-1:0] b;
        bit            hs;
        if (!rstn) begin
            exp_q.delete();
            cur.delete();
            pend = 0; err_m = 0; ovf_m = 0; buffered = 0;
            in_frame = 0; dropping = 0; prev_stall = 0;
        end else begin
            w  = {so_tlast, so_tkeep, so_tdata};
            hs = so_tvalid && so_tready;
            check("frames_pending", frames_pending, pend);
            check("drop_err_cnt", drop_err_cnt, STATS ? err_m : 0);
            check("drop_ovf_cnt", drop_ovf_cnt, STATS ? ovf_m : 0);
            check("valid_without_frame", so_tvalid && exp_q.size() == 0, 0);
            if (prev_stall && so_tvalid) check("stall_hold", w, prev_word);
            if (hs && exp_q.size() != 0) begin
                check("out_beat", w, exp_q.pop_front());
                out_beats++;
                buffered--;
                if (so_tlast) last_keep = so_tkeep;
            end
            prev_stall = so_tvalid && !so_tready;
            prev_word  = w;
            if (rx_tvalid) begin
                b = {rx_tlast, rx_tkeep, rx_tdata};
                if (dropping) begin
                    if (rx_tlast) dropping = 0;
                end else begin
                    if (!in_frame) begin
                        if (pend == MAXF) begin
                            ovf_m++;
                            dropping = !rx_tlast;
                        end else begin
                            in_frame = 1;
                            cur.delete();
                        end
                    end
                    if (in_frame) begin
                        cur.push_back(b);
                        if (cur.size() > DEPTH - buffered) begin
                            ovf_m++;
                            in_frame = 0;
                            dropping = !rx_tlast;
                        end else if (rx_tlast) begin
                            in_frame = 0;
                            if (rx_tuser) err_m++;
                            else begin
                                foreach (cur[i]) exp_q.push_back(cur[i]);
                                buffered += cur.size();
                                pend++;
                            end
                        end
                    end
                end
            end
            if (hs && so_tlast) pend--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input bit bad, input logic [KW-1:0] lk,
                        input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            rx_tvalid = 1'b1;
            rx_tdata  = base + DW'(i);
            rx_tkeep  = (i == n - 1) ? lk : '1;
            rx_tlast  = (i == n - 1);
            rx_tuser  = (i == n - 1) && bad;
            tick();
        end
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        rx_tuser  = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || so_tvalid) && k < 200) begin
            tick();
            k++;
        end
        check(name, k >= 200, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_out;
        repeat (3) tick();
        check("rst_tvalid", so_tvalid, 0);
        check("rst_tdata", so_tdata, 0);
        check("rst_tkeep", so_tkeep, 0);
        check("rst_tlast", so_tlast, 0);
        check("rst_pending", frames_pending, 0);
        check("rst_err", drop_err_cnt, 0);
        check("rst_ovf", drop_ovf_cnt, 0);
        rstn = 1'b1;
        tick();

        // 4-beat good frame, first beat two cycles after tlast
        so_tready = 1'b1;
        base_out = out_beats;
        send(4, 0, 4'b0011, 32'h100);
        check("t1_valid_c1", so_tvalid, 0);
        check("t1_pending_1", frames_pending, 1);
        tick();
        check("t1_valid_c2", so_tvalid, 1);
        check("t1_first_data", so_tdata, 32'h100);
        drain("t1_drain");
        tick();
        check("t1_beats", out_beats - base_out, 4);
        check("t1_last_keep", last_keep, 4'b0011);
        check("t1_pending_0", frames_pending, 0);

        // good, errored, good
        base_out = out_beats;
        send(3, 0, 4'hF, 32'h200);
        send(5, 1, 4'hF, 32'h210);
        send(2, 0, 4'h1, 32'h220);
        drain("t2_drain");
        check("t2_beats", out_beats - base_out, 5);
        check("t2_err", drop_err_cnt, STATS ? 1 : 0);

        // oversize frame then a good one
        base_out = out_beats;
        send(20, 0, 4'hF, 32'h300);
        tick();
        check("t3_no_out", out_beats - base_out, 0);
        check("t3_ovf", drop_ovf_cnt, STATS ? 1 : 0);
        send(4, 0, 4'h7, 32'h340);
        drain("t3_drain");
        check("t3_beats", out_beats - base_out, 4);

        // frame-queue overflow under backpressure
        so_tready = 1'b0;
        base_out = out_beats;
        for (int f = 0; f < 5; f++) send(1, 0, 4'hF, 32'h400 + 32'(f));
        tick();
        check("t4_pending", frames_pending, 4);
        check("t4_ovf", drop_ovf_cnt, STATS ? 2 : 0);
        so_tready = 1'b1;
        drain("t4_drain");
        check("t4_beats", out_beats - base_out, 4);

        // commit coincides with final output tlast handshake
        so_tready = 1'b0;
        send(1, 0, 4'hF, 32'h500);
        repeat (3) tick();
        check("t5_pending_pre", frames_pending, 1);
        rx_tvalid = 1'b1; rx_tdata = 32'h510; rx_tkeep = 4'hF;
        tick();
        rx_tdata = 32'h511; rx_tlast = 1'b1; so_tready = 1'b1;
        tick();
        rx_tvalid = 1'b0; rx_tlast = 1'b0;
        check("t5_pending_same", frames_pending, 1);
        drain("t5_drain");
        tick();
        check("t5_pending_0", frames_pending, 0);

        // reset mid-frame with two frames buffered
        so_tready = 1'b0;
        send(2, 0, 4'hF, 32'h600);
        send(2, 0, 4'hF, 32'h610);
        rx_tvalid = 1'b1; rx_tdata = 32'h620; rx_tkeep = 4'hF;
        tick();
        check("t6_pending_pre", frames_pending, 2);
        rstn = 1'b0;
        rx_tvalid = 1'b0;
        #1;
        check("t6_rst_tvalid", so_tvalid, 0);
        check("t6_rst_tdata", so_tdata, 0);
        check("t6_rst_pending", frames_pending, 0);
        tick();
        tick();
        rstn = 1'b1;
        so_tready = 1'b1;
        tick();
        base_out = out_beats;
        send(3, 0, 4'h3, 32'h700);
        drain("t6_drain");
        check("t6_beats", out_beats - base_out, 3);
        check("t6_last_keep", last_keep, 4'h3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
